// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and counter width helper for the switch debouncer
package debounce_pkg;

  typedef enum logic [1:0] {IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW} debounce_state_t;

  // Counter wide enough to hold 0..n without wrapping.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, symmetric debounce FSM and registered edge pulses for one pin.
// Optional auto-repeat while held is built only when HOLD_REPEAT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int INPUT_ACTIVE_LOW = 0,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic repeat_pulse,
  output logic level_next
);

  localparam int CW = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic sync_q;
  logic rise_next;
  logic fall_next;
  debounce_state_t state;
  logic [CW-1:0] count;

  always_ff @(posedge clk)
    sync_ff <= !reset ? '0 : {sync_ff[SYNC_STAGES-2:0], raw};

  assign sync_q = (INPUT_ACTIVE_LOW != 0) ? ~sync_ff[SYNC_STAGES-1] : sync_ff[SYNC_STAGES-1];

  // A single-cycle debounce qualifies directly from the idle state.
  always_comb begin
    rise_next = sync_q && ((state == PEND_HIGH && count == LAST) || (state == IDLE_LOW && DEBOUNCE_CYCLES == 1));
    fall_next = !sync_q && ((state == PEND_LOW && count == LAST) || (state == IDLE_HIGH && DEBOUNCE_CYCLES == 1));
    level_next = rise_next || (level && !fall_next);
  end

  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE_LOW;
      count <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      level <= level_next;
      rise <= rise_next;
      fall <= fall_next;
      case (state)
        IDLE_LOW:
          if (rise_next) state <= IDLE_HIGH;
          else if (sync_q) begin
            state <= PEND_HIGH;
            count <= CW'(1);
          end
        PEND_HIGH:
          if (rise_next) begin
            state <= IDLE_HIGH;
            count <= '0;
          end else if (!sync_q) begin
            state <= IDLE_LOW;
            count <= '0;
          end else count <= count + CW'(1);
        IDLE_HIGH:
          if (fall_next) state <= IDLE_LOW;
          else if (!sync_q) begin
            state <= PEND_LOW;
            count <= CW'(1);
          end
        PEND_LOW:
          if (fall_next) begin
            state <= IDLE_LOW;
            count <= '0;
          end else if (sync_q) begin
            state <= IDLE_HIGH;
            count <= '0;
          end else count <= count + CW'(1);
        default: state <= IDLE_LOW;
      endcase
    end

`ifdef HOLD_REPEAT_EN
  localparam int RW = count_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] NEXT = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic repeated;

  // Counting starts in the rise-pulse cycle, so repeats can never overlap it.
  always_ff @(posedge clk)
    if (!reset || !level || !level_next) begin
      rcnt <= '0;
      repeated <= 1'b0;
      repeat_pulse <= 1'b0;
    end else if (rcnt == (repeated ? NEXT : FIRST)) begin
      rcnt <= '0;
      repeated <= 1'b1;
      repeat_pulse <= 1'b1;
    end else begin
      rcnt <= rcnt + RW'(1);
      repeat_pulse <= 1'b0;
    end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_switch_debouncer.sv
// multi_switch_debouncer: N independent debounced channels plus a registered any-pressed flag.
// Auto-repeat outputs are active only when HOLD_REPEAT_EN is defined.
module multi_switch_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int INPUT_ACTIVE_LOW = 0,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_inputs,
  output logic [CHANNELS-1:0] debounced_values,
  output logic [CHANNELS-1:0] rise_pulses,
  output logic [CHANNELS-1:0] fall_pulses,
  output logic                any_pressed,
  output logic [CHANNELS-1:0] repeat_pulses
);

  logic [CHANNELS-1:0] level_next;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .INPUT_ACTIVE_LOW(INPUT_ACTIVE_LOW),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(raw_inputs[c]),
      .level(debounced_values[c]),
      .rise(rise_pulses[c]),
      .fall(fall_pulses[c]),
      .repeat_pulse(repeat_pulses[c]),
      .level_next(level_next[c])
    );
  end

  // Built from next-state levels so it lands in the same cycle as debounced_values.
  always_ff @(posedge clk)
    any_pressed <= !reset ? 1'b0 : |level_next;

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// tb_multi_switch_debouncer: directed stimulus with an expected-event queue checked by a monitor.
module tb_multi_switch_debouncer;

  typedef struct {
    int cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rep;
    logic [3:0] level;
    logic any;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] raw_inputs;
  logic [3:0] debounced_values;
  logic [3:0] rise_pulses;
  logic [3:0] fall_pulses;
  logic any_pressed;
  logic [3:0] repeat_pulses;

  int edge_n = 0;
  int total = 0;
  int bad = 0;
  ev_t exp_q[$];

  multi_switch_debouncer #(
    .CHANNELS(4),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2),
    .INPUT_ACTIVE_LOW(0),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_inputs(raw_inputs),
    .debounced_values(debounced_values),
    .rise_pulses(rise_pulses),
    .fall_pulses(fall_pulses),
    .any_pressed(any_pressed),
    .repeat_pulses(repeat_pulses)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic push(input int cyc, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p,
                      input logic [3:0] l, input logic a);
    ev_t e;
    e.cyc = cyc;
    e.rise = r;
    e.fall = f;
    e.rep = p;
    e.level = l;
    e.any = a;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the next queued event; overdue events are reported missing.
  always @(negedge clk) begin
    if ((rise_pulses | fall_pulses | repeat_pulses) != 4'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse at edge %0d: rise=%b fall=%b rep=%b expected none",
                 edge_n, rise_pulses, fall_pulses, repeat_pulses);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_edge", edge_n, e.cyc);
        chk("rise_pulses", int'(rise_pulses), int'(e.rise));
        chk("fall_pulses", int'(fall_pulses), int'(e.fall));
        chk("repeat_pulses", int'(repeat_pulses), int'(e.rep));
        chk("debounced_values", int'(debounced_values), int'(e.level));
        chk("any_pressed", int'(any_pressed), int'(e.any));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < edge_n) begin
      total++;
      bad++;
      $display("FAIL missing_event at edge %0d: no pulse, expected one at edge %0d", edge_n, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0;
    raw_inputs = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_level", int'(debounced_values), 0);
      chk("reset_pulses", int'(rise_pulses | fall_pulses | repeat_pulses), 0);
      chk("reset_any", int'(any_pressed), 0);
    end
    // Release with all pins held: rise on every channel 6 edges later.
    reset = 1'b1;
    push(9, 4'b1111, 4'b0, 4'b0, 4'b1111, 1'b1);
    tick(5);
    chk("pre_rise_level", int'(debounced_values), 0);
    tick(2);
    chk("rise_one_cycle", int'(rise_pulses), 0);
    chk("held_level", int'(debounced_values), 4'b1111);
    raw_inputs = 4'b0000;
    push(16, 4'b0, 4'b1111, 4'b0, 4'b0, 1'b0);
    tick(8);
    // Short 3-cycle glitch on channel 0 is rejected.
    raw_inputs = 4'b0001;
    tick(3);
    raw_inputs = 4'b0000;
    tick(10);
    chk("glitch_level", int'(debounced_values), 0);
    chk("glitch_any", int'(any_pressed), 0);
    // Channel 1 held for 20 cycles.
    raw_inputs = 4'b0010;
    push(37, 4'b0010, 4'b0, 4'b0, 4'b0010, 1'b1);
    tick(7);
    chk("ch1_any_held", int'(any_pressed), 1);
    chk("ch1_rise_width", int'(rise_pulses), 0);
    tick(13);
    raw_inputs = 4'b0000;
    push(57, 4'b0, 4'b0010, 4'b0, 4'b0, 1'b0);
    tick(10);
    chk("ch1_released_any", int'(any_pressed), 0);
    // Bouncing channel 2 settles high: one rise after the last bounce.
    raw_inputs = 4'b0100;
    tick(1);
    raw_inputs = 4'b0000;
    tick(1);
    raw_inputs = 4'b0100;
    tick(1);
    raw_inputs = 4'b0000;
    tick(1);
    raw_inputs = 4'b0100;
    push(71, 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b1);
    tick(8);
    // Channel 3 reset while pending with count 2.
    raw_inputs = 4'b1100;
    tick(4);
    chk("ch3_pending_level", int'(debounced_values), 4'b0100);
    reset = 1'b0;
    tick(1);
    chk("midreset_level", int'(debounced_values), 0);
    chk("midreset_any", int'(any_pressed), 0);
    reset = 1'b1;
    push(84, 4'b1100, 4'b0, 4'b0, 4'b1100, 1'b1);
    tick(8);
    raw_inputs = 4'b0000;
    push(92, 4'b0, 4'b1100, 4'b0, 4'b0, 1'b0);
    tick(8);
    // Channel 0 long hold; repeats fire only with the repeat feature built in.
    raw_inputs = 4'b0001;
    push(100, 4'b0001, 4'b0, 4'b0, 4'b0001, 1'b1);
`ifdef HOLD_REPEAT_EN
    push(110, 4'b0, 4'b0, 4'b0001, 4'b0001, 1'b1);
    push(115, 4'b0, 4'b0, 4'b0001, 4'b0001, 1'b1);
    push(120, 4'b0, 4'b0, 4'b0001, 4'b0001, 1'b1);
`endif
    tick(23);
    raw_inputs = 4'b0000;
    push(123, 4'b0, 4'b0001, 4'b0, 4'b0, 1'b0);
    tick(20);
    chk("final_level", int'(debounced_values), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_switch_debouncer.md
Name: multi_switch_debouncer

Overview:
Parametrised N-channel successor to the single-switch debouncer. Each channel synchronises a raw pin, debounces both press and release symmetrically, and emits registered level, rise-pulse and fall-pulse outputs. Intended for keypad rows/columns and board buttons feeding scanner and FSM logic, so downstream blocks consume clean single-cycle events instead of doing their own edge detection.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the output changes (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
INPUT_ACTIVE_LOW, 0, 1 = raw pin low means pressed (inverted after the synchroniser)
REPEAT_DELAY, 500000, cycles held before the first auto-repeat pulse (HOLD_REPEAT_EN only)
REPEAT_PERIOD, 100000, cycles between later auto-repeat pulses (HOLD_REPEAT_EN only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
raw_inputs  input  CHANNELS  asynchronous pins straight from the board
debounced_values  output  CHANNELS  clean level per channel, 1 = pressed
rise_pulses  output  CHANNELS  one-cycle pulse on debounced 0->1
fall_pulses  output  CHANNELS  one-cycle pulse on debounced 1->0
any_pressed  output  1  OR of debounced_values, registered
repeat_pulses  output  CHANNELS  auto-repeat events; constant 0 without HOLD_REPEAT_EN

Behaviour:
- Reset (reset==0 at posedge clk): all sync flops, counters, FSMs and outputs go to 0. Released state is the idle level. Every output is registered, with no combinational path from raw_inputs.
- Synchroniser: SYNC_STAGES flop chain per channel; if INPUT_ACTIVE_LOW, the last stage is inverted to form sync_q.
- Per-channel FSM with states IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - IDLE_LOW: sync_q==1 -> PEND_HIGH with count=1. If DEBOUNCE_CYCLES==1, go straight to IDLE_HIGH and assert the rise pulse.
  - PEND_HIGH: sync_q==0 -> IDLE_LOW, count=0 (glitch rejected). sync_q==1 and count==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, debounced=1, rise pulse. Otherwise count++.
  - IDLE_HIGH and PEND_LOW mirror the above with polarity swapped; the fall pulse fires on entry to IDLE_LOW.
- Latency: a clean raw edge appears on debounced_values exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges later. The rise/fall pulse is asserted in the same cycle the level changes, for exactly 1 cycle.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change and no pulse.
- The counter saturates by construction: it clears on every state change and never wraps.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- any_pressed is the registered OR of the next-state debounced values, so it is cycle-aligned with debounced_values.
- Reset mid-count discards the pending transition. After reset release, a pin held high produces a rise pulse after the full SYNC_STAGES+DEBOUNCE_CYCLES latency.

Optional Feature:
Macro HOLD_REPEAT_EN.
- Defined: a per-channel repeat counter runs while in IDLE_HIGH or PEND_LOW.
  - repeat_pulses[i] fires 1 cycle at REPEAT_DELAY cycles after the rise pulse, then every REPEAT_PERIOD cycles.
  - The counter clears on entry to IDLE_LOW and on reset.
  - A repeat pulse never coincides with a rise pulse.
- Not defined: repeat_pulses is tied to 0, no repeat logic is synthesised, and the repeat parameters are ignored.

Decomposition:
- Package debounce_pkg: enum debounce_state_t {IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW} and a localparam helper for counter width.
- Sub-module debounce_channel: one synchroniser, FSM, counter and optional repeat logic per channel.
- Top level: generate loop over CHANNELS plus the any_pressed register.

Test Plan:
1. CHANNELS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2; reset low 3 cycles with raw_inputs=4'b1111 -> all outputs 0 during reset. After release, debounced_values=4'b1111 exactly 6 edges later, with rise_pulses=4'b1111 for one cycle.
2. raw_inputs[0] pulse high for 3 cycles -> no change on debounced_values[0], rise_pulses[0] or any_pressed.
3. raw_inputs[1] high for 20 cycles, then low -> rise_pulses[1] at edge 6; fall_pulses[1] 6 edges after the falling edge. Each pulse is 1 cycle wide; any_pressed tracks debounced_values[1].
4. Bouncing input: 1,0,1,0,1, then steady 1 on channel 2 -> a single rise pulse, 6 edges after the last bounce.
5. Assert reset while channel 3 is in PEND_HIGH with count=2 -> count cleared, no pulse. A held input re-qualifies with the full 6-edge latency.
6. HOLD_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, channel 0 held -> repeat pulses 10, 15 and 20 cycles after the rise pulse, none after release.
